// File: rtl/gray_pkg.sv
// Shared types and the binary-to-Gray helper for the Gray conversion arbiter.
package gray_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int GRAY_MAX_W    = 32;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Operates on a zero-extended word. Callers keep the low WIDTH bits; the
    // top kept bit then comes out as bin[WIDTH-1] ^ 0, which is the MSB rule.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps from NREQ-1 to 0.
module rr_arbiter
#(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
)
(
    input  logic [NREQ-1:0] req,
    input  logic            enable,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            any_grant
);

    int idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        idx       = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (enable && !any_grant && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = IDW'(idx);
                any_grant  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin shares one registered binary-to-Gray stage among NREQ producers;
// each result carries the index of the requester it came from.
module gray_conv_arbiter
    import gray_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int IDW   = $clog2(NREQ)
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_gray,
    output logic [IDW-1:0]        out_id,
    input  logic                  out_ready
);

    // Handshakes: a word moves on any edge where valid and ready are both high.
    // req_ready is a combinational function of req_valid (never the reverse),
    // and a producer holding valid without ready keeps its word; nothing is
    // latched from it until the handshake edge.

    state_t                 state_q;
    state_t                 state_d;
    logic [IDW-1:0]         ptr_q;
    logic                   can_accept;
    logic                   arb_enable;
    logic [NREQ-1:0]        grant;
    logic [IDW-1:0]         grant_idx;
    logic                   any_grant;
    logic [WIDTH-1:0]       sel_bin;
    logic [GRAY_MAX_W-1:0]  sel_gray;

    assign can_accept = (state_q == EMPTY) || out_ready;
    assign arb_enable = can_accept && !rst;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr_arbiter (
        .req       (req_valid),
        .enable    (arb_enable),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    assign req_ready = grant;
    assign sel_bin   = req_data[int'(grant_idx)*WIDTH +: WIDTH];
    assign sel_gray  = bin2gray(GRAY_MAX_W'(sel_bin));
    assign out_valid = (state_q == FULL);

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (any_grant) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (out_ready && !any_grant) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // The buffer only loads on a grant, so a stalled FULL entry holds naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= EMPTY;
            ptr_q    <= '0;
            out_gray <= '0;
            out_id   <= '0;
        end else begin
            state_q <= state_d;
            if (any_grant) begin
                out_gray <= sel_gray[WIDTH-1:0];
                out_id   <= grant_idx;
                if (grant_idx == IDW'(NREQ-1)) begin
                    ptr_q <= '0;
                end else begin
                    ptr_q <= grant_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Directed bench for gray_conv_arbiter with a round-robin reference model and result scoreboard.
module tb_gray_conv_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 4;
    localparam int IDW   = 2;
    localparam int W     = IDW + WIDTH;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ*WIDTH-1:0] req_data = '0;
    logic [NREQ-1:0]       req_ready;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_gray;
    logic [IDW-1:0]        out_id;
    logic                  out_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_exp = '0;
    int           m_ptr = 0;
    logic         m_full = 1'b0;
    int           g;
    logic [3:0]   gray_seq [16];
    int           wrap_ids [4];
    int           fair_ids [6];

    gray_conv_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_gray  (out_gray),
        .out_id    (out_id),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] ref_gray(input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        r[WIDTH-1] = b[WIDTH-1];
        for (int k = 0; k < WIDTH-1; k++) r[k] = b[k+1] ^ b[k];
        return r;
    endfunction

    function automatic logic [15:0] pack(input logic [3:0] d0, input logic [3:0] d1,
                                         input logic [3:0] d2, input logic [3:0] d3);
        return {d3, d2, d1, d0};
    endfunction

    // One clock: drive inputs, check grant against the model, clock, check outputs.
    task automatic cycle(input logic [3:0] v, input logic [15:0] d, input logic ordy,
                         input string tag, output int gi);
        logic [NREQ-1:0] exp_ready;
        logic [W-1:0]    e;
        int              idx;
        req_valid = v;
        req_data  = d;
        out_ready = ordy;
        #1;
        gi = -1;
        if (!m_full || ordy) begin
            for (int i = 0; i < NREQ; i++) begin
                idx = (m_ptr + i) % NREQ;
                if (gi < 0 && v[idx]) gi = idx;
            end
        end
        exp_ready = '0;
        if (gi >= 0) begin
            exp_ready[gi] = 1'b1;
            exp_q.push_back({IDW'(gi), ref_gray(d[gi*WIDTH +: WIDTH])});
        end
        check({tag, "_req_ready"}, 32'(req_ready), 32'(exp_ready));
        @(posedge clk);
        if (gi >= 0) begin
            m_full = 1'b1;
            m_ptr  = (gi + 1) % NREQ;
        end else if (ordy) begin
            m_full = 1'b0;
        end
        #1;
        check({tag, "_out_valid"}, 32'(out_valid), 32'(m_full));
        if (gi >= 0) begin
            if (exp_q.size() == 0) begin
                check({tag, "_queue_underflow"}, 32'(1), 32'(0));
            end else begin
                e = exp_q.pop_front();
                last_exp = e;
            end
        end
        if (m_full) begin
            check({tag, "_out_gray"}, 32'(out_gray), 32'(last_exp[WIDTH-1:0]));
            check({tag, "_out_id"}, 32'(out_id), 32'(last_exp[W-1:WIDTH]));
        end
    endtask

    task automatic do_reset(input int n);
        rst       = 1'b1;
        req_valid = 4'hF;
        out_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check("rst_req_ready", 32'(req_ready), 32'(0));
            check("rst_out_valid", 32'(out_valid), 32'(0));
            check("rst_out_gray", 32'(out_gray), 32'(0));
            check("rst_out_id", 32'(out_id), 32'(0));
        end
        rst    = 1'b0;
        m_ptr  = 0;
        m_full = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        gray_seq = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                     4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};
        wrap_ids = '{3, 0, 3, 0};
        fair_ids = '{0, 1, 2, 3, 0, 1};

        // Reset, then a single requester.
        do_reset(2);
        cycle(4'b0100, pack(4'd0, 4'd0, 4'd5, 4'd0), 1'b1, "single", g);
        check("single_gray_lit", 32'(out_gray), 32'(4'b0111));
        check("single_id_lit", 32'(out_id), 32'(2));

        // Round-robin fairness from a fresh pointer.
        do_reset(2);
        for (int i = 0; i < 6; i++) begin
            cycle(4'hF, 16'($urandom_range(0, 65535)), 1'b1, "fair", g);
            check("fair_grant_order", 32'(g), 32'(fair_ids[i]));
            check("fair_id_order", 32'(out_id), 32'(fair_ids[i]));
        end

        // Backpressure with bin 15 in the buffer.
        cycle(4'b0001, pack(4'd15, 4'd0, 4'd0, 4'd0), 1'b1, "bp_load", g);
        check("bp_gray_lit", 32'(out_gray), 32'(4'b1000));
        for (int i = 0; i < 5; i++) begin
            cycle(4'hF, 16'($urandom_range(0, 65535)), 1'b0, "bp_stall", g);
            check("bp_hold_gray", 32'(out_gray), 32'(4'b1000));
            check("bp_hold_id", 32'(out_id), 32'(0));
        end
        cycle(4'hF, 16'($urandom_range(0, 65535)), 1'b1, "bp_release", g);
        check("bp_next_grant", 32'(g), 32'(1));

        // Exhaustive conversion through requester 1.
        for (int i = 0; i < 16; i++) begin
            cycle(4'b0010, pack(4'($urandom_range(0, 15)), 4'(i), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15))), 1'b1, "sweep", g);
            check("sweep_gray_lit", 32'(out_gray), 32'(gray_seq[i]));
        end

        // Pointer wrap with a gap: only 3 and 0 valid after ptr is parked at 3.
        cycle(4'b0100, 16'($urandom_range(0, 65535)), 1'b1, "wrap_park", g);
        for (int i = 0; i < 4; i++) begin
            cycle(4'b1001, 16'($urandom_range(0, 65535)), 1'b1, "wrap", g);
            check("wrap_id_order", 32'(out_id), 32'(wrap_ids[i]));
        end

        // Reset while FULL and stalled.
        cycle(4'b0010, pack(4'd0, 4'd9, 4'd0, 4'd0), 1'b1, "mid_load", g);
        cycle(4'b0000, 16'h0, 1'b0, "mid_hold", g);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'(0));
        check("mid_rst_gray", 32'(out_gray), 32'(0));
        check("mid_rst_id", 32'(out_id), 32'(0));
        rst    = 1'b0;
        m_ptr  = 0;
        m_full = 1'b0;
        exp_q.delete();
        cycle(4'hF, 16'($urandom_range(0, 65535)), 1'b1, "post_rst", g);
        check("post_rst_grant", 32'(g), 32'(0));
        cycle(4'h0, 16'h0, 1'b1, "drain", g);
        check("drain_queue_empty", 32'(exp_q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gray_conv_arbiter.md
Name: gray_conv_arbiter

Overview:
- Shares one registered binary-to-Gray conversion stage among NREQ requesters.
- Uses round-robin arbitration with valid/ready handshakes on both sides.
- Sits between multiple binary-count producers (counters, address generators) and a single Gray-coded consumer (e.g. a CDC pointer path).
- Each result is tagged with the index of the requester that produced it.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 4, binary/Gray word width.
- IDW, clog2(NREQ), requester-id width (derived, not overridable).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NREQ  per-requester data-valid.
- req_data  in  NREQ*WIDTH  packed binary words; requester i occupies bits [i*WIDTH +: WIDTH].
- req_ready  out  NREQ  per-requester accept (one-hot or zero).
- out_valid  out  1  Gray result valid.
- out_gray  out  WIDTH  Gray-coded result.
- out_id  out  IDW  index of the requester that produced out_gray.
- out_ready  in  1  consumer accept.

Behaviour:
- Reset: synchronous and active-high. While rst is sampled high:
  - out_valid=0, out_gray=0, out_id=0.
  - Round-robin pointer is 0, so requester 0 has highest priority on the first post-reset cycle.
  - State is EMPTY.
  - req_ready=0 during reset cycles.
- Reset mid-transaction discards the buffered result; nothing is replayed.
- Conversion: gray[WIDTH-1]=bin[WIDTH-1]; gray[k]=bin[k+1]^bin[k] for k<WIDTH-1.
- Output buffer FSM (single entry):
  - EMPTY: out_valid=0. If any grant is issued -> FULL.
  - FULL: out_valid=1.
    - out_ready=1 with a new grant -> stay FULL, reload buffer (back-to-back).
    - out_ready=1 with no grant -> EMPTY.
    - out_ready=0 -> hold out_gray/out_id stable, issue no grants.
- can_accept = (state==EMPTY) | out_ready.
- Arbitration:
  - When can_accept, grant the first requester with req_valid=1, searching ptr, ptr+1, … NREQ-1, 0, … (wrap-around).
  - req_ready[g]=1 for the granted index only, combinationally in the same cycle.
  - req_ready depends on req_valid; producers must not make req_valid depend on req_ready.
  - No requester valid or !can_accept -> req_ready all zero.
- Accepted handshake (req_valid[g]&req_ready[g]) on edge N:
  - out_gray=gray(req_data[g]) and out_id=g appear after edge N, i.e. valid in cycle N+1 (latency 1).
  - ptr <= (g+1) mod NREQ.
- ptr changes only on an accepted grant.
- Throughput: one result per cycle while out_ready stays high.
- Fairness: a continuously valid requester is granted within NREQ accepted transactions.
- Stall: while out_ready=0 in FULL, req_data changes are ignored and no requester is acknowledged.
- A requester that drops req_valid before being granted loses nothing; nothing is latched from it.
- NREQ not a power of two: wrap from NREQ-1 to 0. Pointer values ≥NREQ are unreachable.

Decomposition:
- Package gray_pkg:
  - function bin2gray(width-generic via WIDTH constant).
  - typedef state_t {EMPTY, FULL}.
  - localparam default WIDTH=4.
- One sub-module: rr_arbiter.
  - Parameter NREQ.
  - Inputs: req vector, enable, ptr.
  - Outputs: one-hot grant, grant index, any_grant.
  - Fully combinational; the pointer register stays in gray_conv_arbiter.

Test Plan:
- Reset then single requester: rst 2 cycles; req_valid=4'b0100, req_data[2]=4'd5 -> req_ready=4'b0100 that cycle; next cycle out_valid=1, out_gray=4'b0111, out_id=2.
- Round-robin fairness: all req_valid=1 continuously, out_ready=1 -> grant order 0,1,2,3,0,1 over six cycles; out_id follows the same order, one per cycle.
- Backpressure: out_ready=0 while FULL with out_gray=4'b1000 (bin 15) for 5 cycles -> out_gray/out_id stable, req_ready=0 all; on release, the next grant follows the stalled id.
- Exhaustive conversion: requester 1 sweeps bin 0..15 with out_ready=1 -> out_gray sequence 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8 (decimal).
- Pointer wrap with a gap: only requesters 3 and 0 valid, ptr=3 -> grants 3,0,3,0; ptr never lands on 1 or 2 without a grant.
- Reset mid-operation: FULL with out_valid=1 and out_ready=0, assert rst -> next cycle out_valid=0, out_gray=0, out_id=0; first post-reset grant goes to requester 0 when all are valid.
